fifo_fwft_flags: RTL and testbench

FIFO_FWFT_FLAGS -- requirements
Module: fifo_fwft_flags

---
 rtl/fifo_fwft_flags.sv | 120 ++++++++++++
 tb/tb_fifo_fwft_flags.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_flags.sv
// Single-clock first-word-fall-through FIFO with registered status flags,
// occupancy count and one-cycle overflow/underflow pulses.
module fifo_fwft_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] TWO_C    = (ADDR_WIDTH+1)'(2);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  full_r, empty_r, afull_r, aempty_r, ovf_r, unf_r;

  logic                  wr_ok_s, rd_ok_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s, rd_ptr_inc_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic [DATA_WIDTH-1:0] dout_nxt_s;

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign count        = count_r;
  assign dout         = dout_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

  // Acceptance, next pointers/count and next head word.
  always_comb begin
    wr_ok_s      = wr_en & ~full_r;
    rd_ok_s      = rd_en & ~empty_r;
    rd_ptr_inc_s = rd_ptr_r + ADDR_WIDTH'(1);
    wr_ptr_nxt_s = wr_ok_s ? (wr_ptr_r + ADDR_WIDTH'(1)) : wr_ptr_r;
    rd_ptr_nxt_s = rd_ok_s ? rd_ptr_inc_s : rd_ptr_r;
    count_nxt_s  = count_r + (ADDR_WIDTH+1)'(wr_ok_s) - (ADDR_WIDTH+1)'(rd_ok_s);
    dout_nxt_s   = dout_r;
    // With one word left, a same-cycle write becomes the new head straight from din.
    if (rd_ok_s) begin
      if (count_r >= TWO_C) begin
        dout_nxt_s = mem_r[rd_ptr_inc_s];
      end else if (wr_ok_s) begin
        dout_nxt_s = din;
      end else begin
        dout_nxt_s = dout_r;
      end
    end else if (wr_ok_s && empty_r) begin
      dout_nxt_s = din;
    end else begin
      dout_nxt_s = dout_r;
    end
  end

  // Storage array; never reset, only read once rewritten.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy, registered flags, head word and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {(ADDR_WIDTH+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      dout_r   <= {DATA_WIDTH{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {(ADDR_WIDTH+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_C);
      empty_r  <= (count_nxt_s == {(ADDR_WIDTH+1){1'b0}});
      afull_r  <= (count_nxt_s >= AFULL_C);
      aempty_r <= (count_nxt_s <= AEMPTY_C);
      dout_r   <= dout_nxt_s;
      ovf_r    <= wr_en & full_r;
      unf_r    <= rd_en & empty_r;
    end
  end

endmodule

// File: tb/tb_fifo_fwft_flags.sv
// Randomized and directed bench for fifo_fwft_flags, checked every cycle
// against a queue-based model of the FIFO behaviour.
module tb_fifo_fwft_flags;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr_en, rd_en;
  logic [7:0] din, dout;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_ovf = 1'b0, m_unf = 1'b0;

  fifo_fwft_flags dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en),
    .full(full), .almost_full(almost_full), .dout(dout), .rd_en(rd_en),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // FIFO semantics as a queue: flags derive from the queue length seen at the edge.
  task automatic model_step(input bit w, input bit r, input bit f, input logic [7:0] d);
    int sz = q.size();
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = w && (sz == 16);
      m_unf = r && (sz == 0);
      if (r && sz > 0) void'(q.pop_front());
      if (w && sz < 16) q.push_back(d);
      if (q.size() > 0) m_dout = q[0];
    end
  endtask

  task automatic cycle(input bit w, input bit r, input bit f, input logic [7:0] d);
    wr_en = w; rd_en = r; flush = f; din = d;
    @(posedge clk);
    #1;
    if (rst_n) model_step(w, r, f, d);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 16));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= 14));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
      chk("dout", 32'(dout), 32'(m_dout));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    model_reset();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout", 32'(dout), 32'h00);
    rst_n = 1'b1;

    cycle(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("a5_empty", 32'(empty), 32'd0);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_count", 32'(count), 32'd1);
    chk("a5_aempty", 32'(almost_empty), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 12) chk("af_at13", 32'(almost_full), 32'd0);
      if (i == 13) chk("af_at14", 32'(almost_full), 32'd1);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    cycle(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("head_after_ovf", 32'(dout), 32'h00);

    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_dout", 32'(dout), 32'h0F);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_dout", 32'(dout), 32'h0F);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("unf_clear", 32'(underflow), 32'd0);

    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(100 + i));
    chk("half_head", 32'(dout), 32'd100);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'(108 + k));
      chk("wrap_count", 32'(count), 32'd8);
      chk("wrap_dout", 32'(dout), 32'(101 + k));
    end

    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
    chk("pre_flush_count", 32'(count), 32'd5);
    cycle(1'b1, 1'b1, 1'b1, 8'h77);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_dout", 32'(dout), 32'h50);
    cycle(1'b1, 1'b0, 1'b0, 8'h3C);
    chk("post_flush_dout", 32'(dout), 32'h3C);
    chk("post_flush_count", 32'(count), 32'd1);

    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    chk("pre_rst_count", 32'(count), 32'd9);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_aempty", 32'(almost_empty), 32'd1);
    chk("arst_dout", 32'(dout), 32'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'h99);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rel_dout", 32'(dout), 32'h00);
    chk("rel_empty", 32'(empty), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 8'h5A);
    chk("rel_write", 32'(dout), 32'h5A);

    for (int blk = 0; blk < 8; blk++) begin
      int wp = $urandom_range(20, 90);
      int rp = $urandom_range(20, 90);
      for (int c = 0; c < 100; c++) begin
        cycle(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
              ($urandom_range(0, 59) == 0), 8'($urandom));
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
